// File: rtl/counter_checker.sv
// On-line checker for the up/down loadable counter: runs a cycle-accurate
// reference model and reports mismatches, statistics and a first-failure snapshot.
module counter_checker #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int CHK_W  = 16,
    parameter int RESYNC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             clr,
    input  logic             load_n,
    input  logic             up_down,
    input  logic             ce,
    input  logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs,
    output logic [CHK_W-1:0] chk_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, CHECK = 2'd2} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   pred_q, pred_d;
    logic               err_q;
    logic [2:0]         err_code_q;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               fail_q;
    logic [WIDTH-1:0]   first_exp_q, first_obs_q;
    logic [CHK_W-1:0]   chk_cnt_q, chk_cnt_d;

    logic [WIDTH-1:0]   nxt_pred, nxt_obs;
    logic [2:0]         mis_bits;
    logic               compare, mismatch;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] v,
                                               input logic ld_n, input logic ud,
                                               input logic en, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = v;
        if (!ld_n)     r = d;
        else if (en)   r = ud ? v + WIDTH'(1) : v - WIDTH'(1);
        return r;
    endfunction

    always_comb begin
        nxt_pred  = model(pred_q, load_n, up_down, ce, data_load);
        nxt_obs   = model(count_out, load_n, up_down, ce, data_load);
        mis_bits  = {count_out != pred_q,
                     max_count != (&pred_q),
                     zero      != (pred_q == '0)};
        compare   = (state_q == CHECK) && chk_en;
        mismatch  = compare && (|mis_bits);
        // A compare discarded by clr must not resync the model either.
        pred_d    = (mismatch && !clr && (RESYNC != 0)) ? nxt_obs : nxt_pred;
        err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
        chk_cnt_d = (&chk_cnt_q) ? chk_cnt_q : chk_cnt_q + CHK_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pred_q      <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_cnt_q   <= '0;
            fail_q      <= 1'b0;
            first_exp_q <= '0;
            first_obs_q <= '0;
            chk_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE:  if (chk_en) state_q <= SYNC;
                SYNC: begin
                    pred_q  <= nxt_obs;
                    state_q <= chk_en ? CHECK : IDLE;
                end
                CHECK: begin
                    if (!chk_en) state_q <= IDLE;
                    else         pred_q  <= pred_d;
                end
                default: state_q <= IDLE;
            endcase

            if (clr) begin
                err_q       <= 1'b0;
                err_code_q  <= '0;
                err_cnt_q   <= '0;
                fail_q      <= 1'b0;
                first_exp_q <= '0;
                first_obs_q <= '0;
                chk_cnt_q   <= '0;
            end else begin
                err_q <= mismatch;
                if (compare) chk_cnt_q <= chk_cnt_d;
                if (mismatch) begin
                    err_code_q <= mis_bits;
                    err_cnt_q  <= err_cnt_d;
                    if (!fail_q) begin
                        fail_q      <= 1'b1;
                        first_exp_q <= pred_q;
                        first_obs_q <= count_out;
                    end
                end
            end
        end
    end

    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;
    assign fail      = fail_q;
    assign first_exp = first_exp_q;
    assign first_obs = first_obs_q;
    assign chk_cnt   = chk_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench: a well-behaved counter drives the checker, with forced
// glitches on count_out / flags to provoke mismatches.
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       chk_en = 1'b0, clr = 1'b0, load_n = 1'b1, up_down = 1'b1, ce = 1'b0;
    logic [3:0] data_load = 4'h0;
    logic [3:0] count_out;
    logic       max_count, zero;
    logic       err, fail;
    logic [2:0] err_code;
    logic [7:0] err_cnt;
    logic [3:0] first_exp, first_obs;
    logic [15:0] chk_cnt;
    logic [1:0] state;

    logic [3:0] cnt;
    logic       f_cnt_en = 1'b0, f_zero_en = 1'b0;
    logic [3:0] f_cnt = 4'h0;

    int checks = 0;
    int errors = 0;

    counter_checker #(.WIDTH(4), .ERR_W(8), .CHK_W(16), .RESYNC(1)) dut (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clr(clr), .load_n(load_n),
        .up_down(up_down), .ce(ce), .data_load(data_load), .count_out(count_out),
        .max_count(max_count), .zero(zero), .err(err), .err_code(err_code),
        .err_cnt(err_cnt), .fail(fail), .first_exp(first_exp), .first_obs(first_obs),
        .chk_cnt(chk_cnt), .state(state)
    );

    always #5 clk = ~clk;

    // Stand-in for the checked counter.
    always @(posedge clk or negedge rst) begin
        if (!rst)           cnt <= 4'h0;
        else if (!load_n)   cnt <= data_load;
        else if (ce)        cnt <= up_down ? cnt + 4'h1 : cnt - 4'h1;
    end

    assign count_out = f_cnt_en  ? f_cnt : cnt;
    assign max_count = (cnt == 4'hF);
    assign zero      = f_zero_en ? 1'b1 : (cnt == 4'h0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_fail", fail, 0);
        chk("rst_chkcnt", chk_cnt, 0);
        chk("rst_fexp", first_exp, 0);

        // Free count up through the wrap
        chk_en = 1; ce = 1; up_down = 1; load_n = 1;
        rst = 1;
        tick(1);
        chk("idle_to_sync", state, 1);
        for (int i = 1; i < 20; i++) begin
            tick(1);
            chk("up_err", err, 0);
        end
        chk("up_chkcnt", chk_cnt, 18);
        chk("up_errcnt", err_cnt, 0);
        chk("up_state", state, 2);

        // Load 3 with ce high, then count down across 0 and F
        load_n = 0; data_load = 4'h3;
        tick(1);
        chk("ld3_err", err, 0);
        load_n = 1; up_down = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("dn_err", err, 0);
        end
        chk("dn_chkcnt", chk_cnt, 24);
        chk("dn_cnt_is_E", count_out, 4'hE);

        // Bring counter to 5, then glitch count_out to 7 while reloading 9
        load_n = 0; data_load = 4'h4; up_down = 1;
        tick(1);
        load_n = 1;
        tick(1);
        f_cnt_en = 1; f_cnt = 4'h7; load_n = 0; data_load = 4'h9;
        tick(1);
        f_cnt_en = 0; load_n = 1;
        chk("g1_err", err, 1);
        chk("g1_code", err_code, 3'b100);
        chk("g1_fail", fail, 1);
        chk("g1_fexp", first_exp, 5);
        chk("g1_fobs", first_obs, 7);
        chk("g1_errcnt", err_cnt, 1);
        tick(1);
        chk("g1_pulse_end", err, 0);
        tick(3);
        chk("g1_resync_errcnt", err_cnt, 1);
        chk("g1_code_hold", err_code, 3'b100);
        chk("g1_chkcnt", chk_cnt, 31);

        // Wrong zero flag at count 2
        load_n = 0; data_load = 4'h2;
        tick(1);
        load_n = 1; f_zero_en = 1;
        tick(1);
        f_zero_en = 0;
        chk("z_err", err, 1);
        chk("z_code", err_code, 3'b001);
        chk("z_errcnt", err_cnt, 2);
        chk("z_fexp", first_exp, 5);
        chk("z_fobs", first_obs, 7);
        tick(1);
        chk("z_pulse_end", err, 0);
        chk("z_chkcnt", chk_cnt, 34);

        // Mismatch on the same edge as clr
        clr = 1; f_cnt_en = 1; f_cnt = 4'hC;
        tick(1);
        clr = 0; f_cnt_en = 0;
        chk("clr_err", err, 0);
        chk("clr_errcnt", err_cnt, 0);
        chk("clr_fail", fail, 0);
        chk("clr_code", err_code, 0);
        chk("clr_fexp", first_exp, 0);
        chk("clr_chkcnt", chk_cnt, 0);
        chk("clr_state", state, 2);
        tick(1);
        chk("post_clr_err", err, 0);
        chk("post_clr_chkcnt", chk_cnt, 1);

        // 300 persistent flag mismatches with the counter held at 6
        ce = 0; f_zero_en = 1;
        tick(254);
        chk("sat_254", err_cnt, 254);
        tick(46);
        chk("sat_255", err_cnt, 255);
        chk("sat_err", err, 1);
        chk("sat_chkcnt", chk_cnt, 301);
        chk("sat_fobs", first_obs, 6);

        // Drop and re-raise chk_en; counter is reloaded while unchecked
        f_zero_en = 0; chk_en = 0; ce = 1; up_down = 1;
        tick(1);
        chk("off_state", state, 0);
        chk("off_err", err, 0);
        chk("off_chkcnt", chk_cnt, 301);
        chk_en = 1; load_n = 0; data_load = 4'hA;
        tick(1);
        chk("resume_sync", state, 1);
        load_n = 1;
        tick(1);
        chk("resume_check", state, 2);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("resume_err", err, 0);
        end
        chk("resume_errcnt", err_cnt, 255);
        chk("resume_chkcnt", chk_cnt, 304);

        // Reset in CHECK returns to IDLE immediately
        #2 rst = 0;
        #1 chk("midrst_state", state, 0);
        chk("midrst_chkcnt", chk_cnt, 0);
        tick(1);
        rst = 1;
        tick(1);
        chk("midrst_sync", state, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Synthesizable on-line checker that sits on the monitor side of the up/down loadable counter.
- It observes every counter control input and output, runs a cycle-accurate reference model, and flags mismatches on count_out, max_count and zero.
- It reports error pulses, saturating statistics and the first-failure snapshot.
- It is used in emulation and standalone benches alongside the counter, sharing its clock and reset.

Parameters:
- WIDTH, 4, counter data width; must match the checked counter.
- ERR_W, 8, width of the saturating error counter.
- CHK_W, 16, width of the saturating checked-cycle counter.
- RESYNC, 1, 1 = model adopts observed count_out after a mismatch; 0 = model runs free.

Ports:
- clk  in  1  clock shared with the checked counter.
- rst  in  1  asynchronous, active-low reset; also the counter's reset.
- chk_en  in  1  checking enable.
- clr  in  1  synchronous clear of errors and statistics.
- load_n  in  1  observed counter load, active low.
- up_down  in  1  observed direction; 1 = up.
- ce  in  1  observed count enable.
- data_load  in  WIDTH  observed load value.
- count_out  in  WIDTH  observed counter value.
- max_count  in  1  observed all-ones flag.
- zero  in  1  observed zero flag.
- err  out  1  one-cycle pulse on mismatch.
- err_code  out  3  mismatch bits {count, max, zero} for the latest error.
- err_cnt  out  ERR_W  saturating mismatch count.
- fail  out  1  sticky; set on first mismatch.
- first_exp  out  WIDTH  expected count_out at first mismatch.
- first_obs  out  WIDTH  observed count_out at first mismatch.
- chk_cnt  out  CHK_W  saturating number of compared cycles.
- state  out  2  FSM state: 0 IDLE, 1 SYNC, 2 CHECK.

Behaviour:
- Reset (rst=0, async): state=IDLE, pred=0, err=0, err_code=0, err_cnt=0, fail=0, first_exp=0, first_obs=0, chk_cnt=0.
- Counter model, applied at each posedge to the current value V:
  - load_n=0 → data_load; load has priority over ce.
  - Else ce=1, up_down=1 → V+1 mod 2^WIDTH (4'hF→0).
  - Else ce=1, up_down=0 → V-1 mod 2^WIDTH (0→4'hF).
  - Else hold V.
- Expected flags are derived from pred: max = (pred == all ones), zero = (pred == 0).
- FSM:
  - IDLE: no compare; pred holds. chk_en=1 → SYNC.
  - SYNC: one cycle; pred ← model(observed count_out, current controls); no compare. chk_en=1 → CHECK, else IDLE.
  - CHECK: compare observed {count_out, max_count, zero} against {pred, expected flags}, then pred ← model(pred) on the next posedge. chk_en=0 → IDLE at that edge, and that cycle is not compared.
- Compare/report, for a mismatch sampled at edge N:
  - err=1 during cycle N+1 only; err_code holds the mismatch bits until the next error or clr.
  - err_cnt += 1, saturating at all ones.
  - If fail=0: first_exp ← pred, first_obs ← count_out, fail ← 1.
  - If RESYNC=1: pred ← model(observed count_out) instead of model(pred).
- chk_cnt increments on every compared edge, saturating at all ones.
- clr=1 (sync):
  - Zeroes err, err_code, err_cnt, fail, first_exp, first_obs and chk_cnt; state and pred are unaffected.
  - clr has priority: a compare on the same edge is discarded and neither counted nor reported.
- Reset mid-CHECK returns to IDLE immediately. The checker must re-pass SYNC after reset, so the first counter cycle after reset is never compared.
- There are no combinational paths from inputs to outputs; all outputs are registered.

Test Plan:
- (WIDTH=4) Reset, chk_en=1, ce=1, up_down=1 for 20 cycles with a correct counter → err never asserts, err_cnt=0, chk_cnt=18, wrap 4'hF→0 passes.
- Load 4'h3 (load_n=0 together with ce=1), then count down 5 times → pred tracks 3,2,1,0,F,E; zero checked at 0 and max_count checked at F; no error.
- Force count_out=4'h7 when 4'h5 is expected, for one cycle → next cycle err=1, err_code=3'b100, fail=1, first_exp=5, first_obs=7, err_cnt=1. With RESYNC=1 there are no further errors once the counter is back in sequence.
- Force zero=1 at count 4'h2 → err_code=3'b001; first_exp and first_obs are unchanged from the earlier failure; err_cnt=2.
- Inject a mismatch on the same edge as clr=1 → err stays 0, err_cnt=0, fail=0.
- Inject 300 mismatches with ERR_W=8 → err_cnt saturates at 255. Drop chk_en, then raise it → state goes CHECK→IDLE→SYNC→CHECK, and checking resumes from the observed count.
